// File: rtl/rsa_job_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// rsa_sched_pkg
// Shared constants and types for the RSA job scheduler.
//   DATA_BITS : stream data width (message/result live in bits [255:0])
//   MOD_BITS  : modulus width
//   EXP_BITS  : exponent width
//   state_t   : scheduler FSM states
//   key_t     : one key-table entry (modulus, exponent)
// ---------------------------------------------------------------------------
package rsa_sched_pkg;

  localparam int DATA_BITS = 512;
  localparam int MOD_BITS  = 256;
  localparam int EXP_BITS  = 20;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SEND = 3'd2,
    WAIT = 3'd3,
    RESP = 3'd4
  } state_t;

  typedef struct packed {
    logic [MOD_BITS-1:0] modulus;
    logic [EXP_BITS-1:0] exponent;
  } key_t;

endpackage

// File: rtl/rsa_job_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rsa_rr_arbiter
// Combinational round-robin picker. Searches the eligible mask starting at
// last_grant+1 and wrapping around; the first set bit wins.
// Ports:
//   eligible   in  NUM_REQ  requesters that may be granted
//   last_grant in  IDX_W    index granted most recently
//   grant      out IDX_W    chosen index (0 when nothing is eligible)
//   found      out 1        at least one requester is eligible
// ---------------------------------------------------------------------------
module rsa_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   grant,
  output logic               found
);

  // Walk from the farthest candidate to the nearest one so that the last
  // match written is the closest after last_grant; no early exit needed.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (eligible[(int'(last_grant) + k) % NUM_REQ]) begin
        grant = IDX_W'((int'(last_grant) + k) % NUM_REQ);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rsa_job_scheduler.sv
// ---------------------------------------------------------------------------
// rsa_job_scheduler
// Shares one RSA modexp engine between NUM_REQ request streams. Each
// requester has its own key in an internal table; requesters are served
// round-robin, one job in flight at a time, and results come back on a
// single AXI4-Stream master tagged with the requester index in tid.
//
// Optional build macro: RSA_SCHED_TIMEOUT_EN adds an engine watchdog
// (TIMEOUT_CYCLES) with ports eng_abort, m_axis_terr and timeout_flag.
//
// Ports:
//   ap_clk, ap_rst              clock, asynchronous active-high reset
//   s_req_*                     request streams, requester i in slice i
//   cfg_we/cfg_clr/cfg_idx/...  key-table write / invalidate
//   eng_modulus/eng_exponent    key latched for the current job
//   eng_msg_*                   message stream to the engine
//   eng_res_*                   result stream from the engine
//   m_axis_*                    result stream out (tid = requester index)
//   busy                        scheduler not idle
// ---------------------------------------------------------------------------
module rsa_job_scheduler
  import rsa_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int IDX_W          = $clog2(NUM_REQ),
  parameter int TID_BITS       = 6,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic [NUM_REQ*DATA_BITS-1:0] s_req_tdata,
  input  logic [NUM_REQ-1:0]           s_req_tvalid,
  output logic [NUM_REQ-1:0]           s_req_tready,
  input  logic                         cfg_we,
  input  logic [IDX_W-1:0]             cfg_idx,
  input  logic [MOD_BITS-1:0]          cfg_modulus,
  input  logic [EXP_BITS-1:0]          cfg_exponent,
  input  logic                         cfg_clr,
  output logic [MOD_BITS-1:0]          eng_modulus,
  output logic [EXP_BITS-1:0]          eng_exponent,
  output logic [DATA_BITS-1:0]         eng_msg_tdata,
  output logic                         eng_msg_tvalid,
  input  logic                         eng_msg_tready,
  input  logic [DATA_BITS-1:0]         eng_res_tdata,
  input  logic                         eng_res_tvalid,
  output logic                         eng_res_tready,
  output logic [DATA_BITS-1:0]         m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [DATA_BITS/8-1:0]       m_axis_tkeep,
  output logic [TID_BITS-1:0]          m_axis_tid,
`ifdef RSA_SCHED_TIMEOUT_EN
  output logic                         eng_abort,
  output logic                         m_axis_terr,
  output logic                         timeout_flag,
`endif
  output logic                         busy
);

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]       last_grant_q, last_grant_d;
  logic [NUM_REQ-1:0]     key_valid_q, key_valid_d;
  logic [MOD_BITS-1:0]    eng_modulus_q, eng_modulus_d;
  logic [EXP_BITS-1:0]    eng_exponent_q, eng_exponent_d;
  logic [DATA_BITS-1:0]   res_data_q, res_data_d;
  logic [TID_BITS-1:0]    tid_q, tid_d;

`ifdef RSA_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic                   terr_q, terr_d;
  logic                   timeout_flag_q, timeout_flag_d;
`endif

  // Key table: plain array, no reset; validity is tracked separately so a
  // reset invalidates every entry without touching the storage.
  key_t                   key_table [NUM_REQ];
  logic                   cfg_in_range;
  logic [DATA_BITS-1:0]   req_slice [NUM_REQ];
  logic [IDX_W-1:0]       arb_grant;
  logic                   arb_found;

  assign cfg_in_range = int'(cfg_idx) < NUM_REQ;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign req_slice[gi] = s_req_tdata[gi*DATA_BITS +: DATA_BITS];
    end
  endgenerate

  always_ff @(posedge ap_clk) begin
    if (cfg_we && cfg_in_range) begin
      key_table[cfg_idx] <= '{modulus: cfg_modulus, exponent: cfg_exponent};
    end
  end

  rsa_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .eligible   (s_req_tvalid & key_valid_q),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .found      (arb_found)
  );

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    key_valid_d    = key_valid_q;
    eng_modulus_d  = eng_modulus_q;
    eng_exponent_d = eng_exponent_q;
    res_data_d     = res_data_q;
    tid_d          = tid_q;
    s_req_tready   = '0;
    eng_msg_tvalid = 1'b0;
    eng_msg_tdata  = '0;
    eng_res_tready = 1'b0;
`ifdef RSA_SCHED_TIMEOUT_EN
    tmo_cnt_d      = tmo_cnt_q;
    terr_d         = terr_q;
    timeout_flag_d = timeout_flag_q;
    eng_abort      = 1'b0;
`endif

    // A write wins over a clear to the same entry.
    if (cfg_we && cfg_in_range) begin
      key_valid_d[cfg_idx] = 1'b1;
    end else if (cfg_clr && cfg_in_range) begin
      key_valid_d[cfg_idx] = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (arb_found) begin
          grant_d      = arb_grant;
          last_grant_d = arb_grant;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        // Snapshot the key so later table writes only affect later jobs.
        eng_modulus_d  = key_table[grant_q].modulus;
        eng_exponent_d = key_table[grant_q].exponent;
        state_d        = SEND;
      end
      SEND: begin
        eng_msg_tvalid        = s_req_tvalid[grant_q];
        eng_msg_tdata         = req_slice[grant_q];
        s_req_tready[grant_q] = eng_msg_tready;
        if (s_req_tvalid[grant_q] && eng_msg_tready) begin
          state_d = WAIT;
`ifdef RSA_SCHED_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      WAIT: begin
        eng_res_tready = 1'b1;
        if (eng_res_tvalid) begin
          res_data_d = eng_res_tdata;
          tid_d      = TID_BITS'(grant_q);
          state_d    = RESP;
`ifdef RSA_SCHED_TIMEOUT_EN
          terr_d     = 1'b0;
        end else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Last permitted WAIT cycle with no result: abort the engine and
          // report an error beat instead of a result.
          eng_abort      = 1'b1;
          res_data_d     = '0;
          tid_d          = TID_BITS'(grant_q);
          terr_d         = 1'b1;
          timeout_flag_d = 1'b1;
          state_d        = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
        end
      end
      RESP: begin
        if (m_axis_tready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      last_grant_q   <= IDX_W'(NUM_REQ - 1);
      key_valid_q    <= '0;
      eng_modulus_q  <= '0;
      eng_exponent_q <= '0;
      res_data_q     <= '0;
      tid_q          <= '0;
`ifdef RSA_SCHED_TIMEOUT_EN
      tmo_cnt_q      <= '0;
      terr_q         <= 1'b0;
      timeout_flag_q <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      last_grant_q   <= last_grant_d;
      key_valid_q    <= key_valid_d;
      eng_modulus_q  <= eng_modulus_d;
      eng_exponent_q <= eng_exponent_d;
      res_data_q     <= res_data_d;
      tid_q          <= tid_d;
`ifdef RSA_SCHED_TIMEOUT_EN
      tmo_cnt_q      <= tmo_cnt_d;
      terr_q         <= terr_d;
      timeout_flag_q <= timeout_flag_d;
`endif
    end
  end

  assign eng_modulus   = eng_modulus_q;
  assign eng_exponent  = eng_exponent_q;
  assign m_axis_tvalid = (state_q == RESP);
  assign m_axis_tdata  = res_data_q;
  assign m_axis_tid    = tid_q;
  assign m_axis_tlast  = m_axis_tvalid;
  assign m_axis_tkeep  = {(DATA_BITS/8){m_axis_tvalid}};
  assign busy          = (state_q != IDLE);
`ifdef RSA_SCHED_TIMEOUT_EN
  assign m_axis_terr   = terr_q & m_axis_tvalid;
  assign timeout_flag  = timeout_flag_q;
`endif

endmodule

// File: doc/rsa_job_scheduler.md
Name: rsa_job_scheduler

Overview:
Shares one RSA modular-exponentiation engine between NUM_REQ requester streams. Each requester index has its own key (modulus, exponent) in an internal key table loaded over a config port. The block picks requesters round-robin, presents the key and message to the engine, captures the engine result, and returns it on one 512-bit AXI4SR master stream tagged with the requester index in tid. At most one job is in flight at any time.

Parameters:
NUM_REQ, 4, number of requester streams (2..16)
IDX_W, $clog2(NUM_REQ), requester index width
DATA_BITS, 512, stream data width; message/result occupy bits [255:0]
MOD_BITS, 256, modulus width
EXP_BITS, 20, exponent width
TID_BITS, 6, output tid width; index zero-extended
TIMEOUT_CYCLES, 4096, engine watchdog limit (RSA_SCHED_TIMEOUT_EN only)

Ports:
ap_clk  in  1  clock
ap_rst  in  1  asynchronous reset, active-high
s_req_tdata  in  NUM_REQ*DATA_BITS  request messages, requester i in slice i
s_req_tvalid  in  NUM_REQ  request valid
s_req_tready  out  NUM_REQ  request ready
cfg_we  in  1  key-table write strobe
cfg_idx  in  IDX_W  key-table entry
cfg_modulus  in  MOD_BITS  modulus to write
cfg_exponent  in  EXP_BITS  exponent to write
cfg_clr  in  1  invalidate entry cfg_idx (ignored when cfg_we=1)
eng_modulus  out  MOD_BITS  latched modulus for the engine
eng_exponent  out  EXP_BITS  latched exponent for the engine
eng_msg_tdata  out  DATA_BITS  message to the engine
eng_msg_tvalid  out  1  message valid
eng_msg_tready  in  1  engine accepts message
eng_res_tdata  in  DATA_BITS  engine result
eng_res_tvalid  in  1  result valid
eng_res_tready  out  1  scheduler accepts result
m_axis_tdata  out  DATA_BITS  result
m_axis_tvalid  out  1  result valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  always 1 while tvalid
m_axis_tkeep  out  DATA_BITS/8  all ones while tvalid
m_axis_tid  out  TID_BITS  requester index
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; all key_valid bits 0; last_grant = NUM_REQ-1; all outputs 0, including the latched eng_modulus and eng_exponent.
- Key table: written on the ap_clk edge when cfg_we=1 (sets key_valid[idx]); cfg_clr clears key_valid[idx]. Writes are allowed in any state.
- Eligible requester: s_req_tvalid[i] && key_valid[i]. A requester with no valid key is never granted and sees tready=0.
- IDLE: if any requester is eligible, grant the first eligible index searching from last_grant+1 with wrap-around. Register grant and last_grant, then go to LOAD.
- LOAD (1 cycle): latch eng_modulus/eng_exponent from the table entry as it stands at the start of the cycle, then go to SEND. Later key writes affect only later jobs.
- SEND: eng_msg_tvalid = s_req_tvalid[grant]; eng_msg_tdata = slice[grant]; s_req_tready[grant] = eng_msg_tready. All other tready bits stay 0. On the handshake go to WAIT. If the requester drops tvalid (protocol violation), stay in SEND.
- WAIT: eng_res_tready=1. On eng_res_tvalid, capture tdata into the output register, set m_axis_tid = grant, go to RESP.
- RESP: m_axis_tvalid=1; data, tid, tlast and tkeep are held stable until m_axis_tready. On the handshake go to IDLE.
- Minimum turnaround is 4 cycles plus engine latency. Back-to-back jobs need no idle bubble beyond the IDLE grant cycle.
- cfg_clr on the entry in use mid-job does not abort the job.
- Asserting ap_rst in any state returns immediately to the reset values. In-flight data is dropped, and the engine is expected to be reset by the same signal.

Optional Feature:
RSA_SCHED_TIMEOUT_EN. When defined, a counter runs in WAIT. When it reaches TIMEOUT_CYCLES with no result:
- pulse output eng_abort for 1 cycle;
- go to RESP with tdata=0 and the extra output m_axis_terr=1 (terr is 0 for normal results);
- set the sticky output timeout_flag, which is cleared only by ap_rst.
When undefined, WAIT has no time limit and the eng_abort, m_axis_terr and timeout_flag ports do not exist.

Decomposition:
- Package rsa_sched_pkg holds: DATA_BITS, MOD_BITS, EXP_BITS constants; state enum {IDLE, LOAD, SEND, WAIT, RESP}; key_t struct {modulus, exponent}.
- One sub-module, rsa_rr_arbiter: a combinational round-robin picker taking an eligible mask and last_grant, returning grant index and a found flag.

Test Plan:
1. Key0 = modulus F4F5E3D2C1B0A9876543210FEDCBA9876543210FEDCBA9876543210FEDCBA98, exponent 0x10001; port 0 sends A5 repeated over 256 bits; engine model answers 0x1234 after 20 cycles -> eng_modulus/eng_exponent match during SEND; m_axis_tdata=0x1234, tid=0, tlast=1, tkeep all ones.
2. Keys on all 4 ports, all tvalid held high -> grant order 0,1,2,3,0,1; each m_axis_tid matches its port.
3. Port 2 tvalid without a key -> s_req_tready[2] stays 0 for 200 cycles; after a cfg_we on idx 2, port 2 is served within one job.
4. m_axis_tready low for 50 cycles in RESP -> tvalid/tdata stable, no new grant, busy=1; tready high -> IDLE next cycle.
5. cfg_we idx 0 with a new modulus during WAIT of a port-0 job -> eng_modulus unchanged for this job; the next port-0 job uses the new value.
6. ap_rst pulsed in WAIT -> all outputs 0 asynchronously, IDLE after release. With RSA_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=1000, a silent engine -> eng_abort at WAIT cycle 1000, then m_axis_terr=1 with tdata=0 and timeout_flag=1.
